// File: rtl/vcu108_stress_test_pkg.sv
// Shared types, constants and CLKOUT0 field math for the stress-test PLL
// runtime reconfiguration controller.
package vcu108_stress_test_pkg;

   typedef enum logic [3:0] {
      ST_INIT      = 4'd0,
      ST_WAIT_LOCK = 4'd1,
      ST_IDLE      = 4'd2,
      ST_HOLD      = 4'd3,
      ST_RD1       = 4'd4,
      ST_WR1       = 4'd5,
      ST_RD2       = 4'd6,
      ST_WR2       = 4'd7,
      ST_RELEASE   = 4'd8
   } state_t;

   localparam logic [6:0]  DEF_ADDR_CLKREG1 = 7'h08;
   localparam logic [6:0]  DEF_ADDR_CLKREG2 = 7'h09;
   // Bits of each register that must survive the read-modify-write
   localparam logic [15:0] CLKREG1_KEEP     = 16'h1000;
   localparam logic [15:0] CLKREG2_KEEP     = 16'hFF00;
   localparam logic [7:0]  MAX_DIVIDE       = 8'd126;

   function automatic logic divide_legal(input logic [7:0] d);
      return (d != 8'd0) && (d <= MAX_DIVIDE);
   endfunction

   // ClkReg1: high/low counts, PHASE_MUX cleared, bit 12 kept from the read
   function automatic logic [15:0] clkreg1_value(input logic [7:0] d, input logic [15:0] rd);
      logic [7:0] hi;
      logic [7:0] lo;
      hi = d >> 1;
      lo = d - hi;
      if (d == 8'd1) begin
         hi = 8'd1;
         lo = 8'd1;
      end
      return (rd & CLKREG1_KEEP) | {4'b0000, hi[5:0], lo[5:0]};
   endfunction

   // ClkReg2: EDGE/NO_COUNT, DELAY_TIME cleared, upper byte kept.
   // Divide-by-1 bypasses the counter, so EDGE is meaningless and left clear.
   function automatic logic [15:0] clkreg2_value(input logic [7:0] d, input logic [15:0] rd);
      logic edge_bit;
      logic nocnt;
      nocnt    = (d == 8'd1);
      edge_bit = d[0] && !nocnt;
      return (rd & CLKREG2_KEEP) | {8'h00, edge_bit, nocnt, 6'b000000};
   endfunction

endpackage

// File: rtl/vcu108_stress_test_drp_access.sv
// One DRP read or write: issues the den pulse, waits for drdy, and gives up
// after DRP_TIMEOUT cycles without a response.
module vcu108_stress_test_drp_access #(
   parameter int DRP_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        we,
   input  logic [6:0]  addr,
   input  logic [15:0] wdata,
   output logic        done,
   output logic [15:0] rdata,
   output logic        timeout,
   output logic [6:0]  drp_daddr,
   output logic        drp_den,
   output logic        drp_dwe,
   output logic [15:0] drp_di,
   input  logic [15:0] drp_do,
   input  logic        drp_drdy
);

   localparam int TW = $clog2(DRP_TIMEOUT + 1);

   logic          pending;
   logic [TW-1:0] tcnt;

   // Access engine: drdy only counts while an access is outstanding
   always_ff @(posedge clk) begin
      if (rst) begin
         pending   <= 1'b0;
         tcnt      <= '0;
         done      <= 1'b0;
         timeout   <= 1'b0;
         rdata     <= 16'h0000;
         drp_den   <= 1'b0;
         drp_dwe   <= 1'b0;
         drp_daddr <= 7'h00;
         drp_di    <= 16'h0000;
      end else begin
         drp_den <= 1'b0;
         drp_dwe <= 1'b0;
         done    <= 1'b0;
         timeout <= 1'b0;
         if (start) begin
            drp_den   <= 1'b1;
            drp_dwe   <= we;
            drp_daddr <= addr;
            drp_di    <= wdata;
            pending   <= 1'b1;
            tcnt      <= '0;
         end else if (pending) begin
            if (drp_drdy) begin
               done    <= 1'b1;
               rdata   <= drp_do;
               pending <= 1'b0;
            end else if (tcnt == TW'(DRP_TIMEOUT - 1)) begin
               timeout <= 1'b1;
               pending <= 1'b0;
            end else begin
               tcnt <= tcnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/vcu108_stress_test_clock_reconfig.sv
// Runtime CLKOUT0 divider reconfiguration for the stress-test PLL: power-up
// PLL reset, then per request hold PLL reset, read-modify-write ClkReg1 and
// ClkReg2 over DRP, release reset and wait for lock.
//
// Request handshake: req_ready is high exactly while the FSM is in IDLE; a
// request is taken on the cycle req_valid && req_ready are both high, and
// req_divide is latched on that cycle. The requester holds req_valid until
// then; nothing is queued.
module vcu108_stress_test_clock_reconfig
   import vcu108_stress_test_pkg::*;
#(
   parameter int         RST_HOLD     = 16,
   parameter int         LOCK_TIMEOUT = 100000,
   parameter int         DRP_TIMEOUT  = 64,
   parameter logic [6:0] ADDR_CLKREG1 = DEF_ADDR_CLKREG1,
   parameter logic [6:0] ADDR_CLKREG2 = DEF_ADDR_CLKREG2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [7:0]  req_divide,
   output logic        req_ready,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [6:0]  drp_daddr,
   output logic        drp_den,
   output logic        drp_dwe,
   output logic [15:0] drp_di,
   input  logic [15:0] drp_do,
   input  logic        drp_drdy,
   output logic        pll_rst,
   input  logic        pll_locked,
   output logic        locked_out
);

   localparam int CNT_MAX = (LOCK_TIMEOUT > RST_HOLD) ? LOCK_TIMEOUT : RST_HOLD;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [7:0]         divide_q;
   logic               err_flag;
   logic               seq_active;
   logic               lock_meta;
   logic               lock_sync;

   logic               acc_start;
   logic               acc_we;
   logic [6:0]         acc_addr;
   logic [15:0]        acc_wdata;
   logic               acc_done;
   logic [15:0]        acc_rdata;
   logic               acc_timeout;

   assign req_ready = (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);

   vcu108_stress_test_drp_access #(
      .DRP_TIMEOUT (DRP_TIMEOUT)
   ) u_drp (
      .clk       (clk),
      .rst       (rst),
      .start     (acc_start),
      .we        (acc_we),
      .addr      (acc_addr),
      .wdata     (acc_wdata),
      .done      (acc_done),
      .rdata     (acc_rdata),
      .timeout   (acc_timeout),
      .drp_daddr (drp_daddr),
      .drp_den   (drp_den),
      .drp_dwe   (drp_dwe),
      .drp_di    (drp_di),
      .drp_do    (drp_do),
      .drp_drdy  (drp_drdy)
   );

   // Two-flop synchroniser for the asynchronous PLL LOCKED pin
   always_ff @(posedge clk) begin
      if (rst) begin
         lock_meta <= 1'b0;
         lock_sync <= 1'b0;
      end else begin
         lock_meta <= pll_locked;
         lock_sync <= lock_meta;
      end
   end

   // Lock indication to the host: only while idle and locked
   always_ff @(posedge clk) begin
      if (rst) begin
         locked_out <= 1'b0;
      end else begin
         locked_out <= lock_sync && (state == ST_IDLE);
      end
   end

   // Sequencer FSM; seq_active keeps the power-up lock from pulsing done
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_INIT;
         cnt        <= '0;
         pll_rst    <= 1'b1;
         done       <= 1'b0;
         error      <= 1'b0;
         divide_q   <= 8'h00;
         err_flag   <= 1'b0;
         seq_active <= 1'b0;
         acc_start  <= 1'b0;
         acc_we     <= 1'b0;
         acc_addr   <= 7'h00;
         acc_wdata  <= 16'h0000;
      end else begin
         done      <= 1'b0;
         error     <= 1'b0;
         acc_start <= 1'b0;
         case (state)
            ST_INIT: begin
               pll_rst <= 1'b1;
               if (cnt == CNT_W'(RST_HOLD - 1)) begin
                  pll_rst <= 1'b0;
                  cnt     <= '0;
                  state   <= ST_WAIT_LOCK;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_WAIT_LOCK: begin
               if (lock_sync) begin
                  done       <= seq_active;
                  error      <= seq_active && err_flag;
                  seq_active <= 1'b0;
                  state      <= ST_IDLE;
               end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                  done       <= seq_active;
                  error      <= seq_active;
                  seq_active <= 1'b0;
                  state      <= ST_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_IDLE: begin
               if (req_valid) begin
                  divide_q <= req_divide;
                  if (divide_legal(req_divide)) begin
                     pll_rst    <= 1'b1;
                     cnt        <= '0;
                     err_flag   <= 1'b0;
                     seq_active <= 1'b1;
                     state      <= ST_HOLD;
                  end else begin
                     done  <= 1'b1;
                     error <= 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               if (cnt == CNT_W'(RST_HOLD - 1)) begin
                  acc_start <= 1'b1;
                  acc_we    <= 1'b0;
                  acc_addr  <= ADDR_CLKREG1;
                  state     <= ST_RD1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_RD1: begin
               if (acc_timeout) begin
                  err_flag <= 1'b1;
                  pll_rst  <= 1'b0;
                  state    <= ST_RELEASE;
               end else if (acc_done) begin
                  acc_start <= 1'b1;
                  acc_we    <= 1'b1;
                  acc_addr  <= ADDR_CLKREG1;
                  acc_wdata <= clkreg1_value(divide_q, acc_rdata);
                  state     <= ST_WR1;
               end
            end
            ST_WR1: begin
               if (acc_timeout) begin
                  err_flag <= 1'b1;
                  pll_rst  <= 1'b0;
                  state    <= ST_RELEASE;
               end else if (acc_done) begin
                  acc_start <= 1'b1;
                  acc_we    <= 1'b0;
                  acc_addr  <= ADDR_CLKREG2;
                  state     <= ST_RD2;
               end
            end
            ST_RD2: begin
               if (acc_timeout) begin
                  err_flag <= 1'b1;
                  pll_rst  <= 1'b0;
                  state    <= ST_RELEASE;
               end else if (acc_done) begin
                  acc_start <= 1'b1;
                  acc_we    <= 1'b1;
                  acc_addr  <= ADDR_CLKREG2;
                  acc_wdata <= clkreg2_value(divide_q, acc_rdata);
                  state     <= ST_WR2;
               end
            end
            ST_WR2: begin
               if (acc_timeout) begin
                  err_flag <= 1'b1;
                  pll_rst  <= 1'b0;
                  state    <= ST_RELEASE;
               end else if (acc_done) begin
                  pll_rst <= 1'b0;
                  state   <= ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               pll_rst <= 1'b0;
               cnt     <= '0;
               state   <= ST_WAIT_LOCK;
            end
            default: begin
               pll_rst <= 1'b1;
               cnt     <= '0;
               state   <= ST_INIT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vcu108_stress_test_clock_reconfig.sv
// Bench for the PLL reconfiguration controller: behavioural PLL with DRP
// register file (drdy 3 cycles after den, lock 200 cycles after reset falls),
// scoreboard queues for DRP writes and completions, randomized requests.
module tb_vcu108_stress_test_clock_reconfig;

   localparam int LOCK_TO = 1000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic [7:0]  req_divide = 8'h00;
   logic        req_ready;
   logic        busy;
   logic        done;
   logic        error;
   logic [6:0]  drp_daddr;
   logic        drp_den;
   logic        drp_dwe;
   logic [15:0] drp_di;
   logic [15:0] drp_do = 16'h0000;
   logic        drp_drdy = 1'b0;
   logic        pll_rst;
   logic        pll_locked = 1'b0;
   logic        locked_out;

   int vectors = 0;
   int miscompares = 0;

   logic [22:0] exp_wr_q[$];
   logic [0:0]  exp_done_q[$];

   logic [15:0] mem [0:127];
   bit          withhold_wr1 = 1'b0;
   bit          never_lock = 1'b0;
   int          rsp_cnt = 0;
   logic [15:0] rsp_data = 16'h0000;
   int          lk_cnt = 0;
   int          den_count = 0;

   always #5 clk = ~clk;

   vcu108_stress_test_clock_reconfig #(
      .LOCK_TIMEOUT (LOCK_TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_divide (req_divide),
      .req_ready  (req_ready),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .drp_daddr  (drp_daddr),
      .drp_den    (drp_den),
      .drp_dwe    (drp_dwe),
      .drp_di     (drp_di),
      .drp_do     (drp_do),
      .drp_drdy   (drp_drdy),
      .pll_rst    (pll_rst),
      .pll_locked (pll_locked),
      .locked_out (locked_out)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference CLKOUT0 encoding from the divide value
   function automatic logic [15:0] ref_w1(input int d, input logic [15:0] r1);
      int hi;
      int lo;
      hi = (d == 1) ? 1 : d / 2;
      lo = (d == 1) ? 1 : d - d / 2;
      return (r1 & 16'h1000) | 16'(hi * 64 + lo);
   endfunction

   function automatic logic [15:0] ref_w2(input int d, input logic [15:0] r2);
      int e;
      int nc;
      e  = ((d % 2) == 1 && d != 1) ? 128 : 0;
      nc = (d == 1) ? 64 : 0;
      return (r2 & 16'hFF00) | 16'(e + nc);
   endfunction

   // DRP register file: answers each access 3 cycles after den
   always @(posedge clk) begin
      drp_drdy <= 1'b0;
      if (rsp_cnt != 0) begin
         rsp_cnt <= rsp_cnt - 1;
         if (rsp_cnt == 1) begin
            drp_drdy <= 1'b1;
            drp_do   <= rsp_data;
         end
      end
      if (drp_den) begin
         rsp_data <= mem[drp_daddr];
         if (drp_dwe) mem[drp_daddr] = drp_di;
         if (!(drp_dwe && withhold_wr1 && drp_daddr == 7'h08)) rsp_cnt <= 3;
      end
   end

   // PLL lock: drops in reset, returns 200 cycles after reset falls
   always @(posedge clk) begin
      if (pll_rst) begin
         lk_cnt     <= 0;
         pll_locked <= 1'b0;
      end else if (lk_cnt < 200) begin
         lk_cnt <= lk_cnt + 1;
      end else begin
         pll_locked <= !never_lock;
      end
   end

   // Monitor: pops expectations whenever the DUT writes DRP or completes
   always @(negedge clk) begin
      logic [22:0] ew;
      logic [0:0]  ed;
      if (drp_den) begin
         den_count++;
         check("pll_rst_during_drp", 32'(pll_rst), 32'd1);
         if (drp_dwe) begin
            if (exp_wr_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_write: got addr %0h data %0h expected none", drp_daddr, drp_di);
            end else begin
               ew = exp_wr_q.pop_front();
               check("drp_write", 32'({drp_daddr, drp_di}), 32'(ew));
            end
         end
      end
      if (done) begin
         if (exp_done_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_done: got done=1 error=%0b expected no completion", error);
         end else begin
            ed = exp_done_q.pop_front();
            check("done_error", 32'(error), 32'(ed));
         end
      end else if (error) begin
         vectors++;
         miscompares++;
         $display("FAIL error_without_done: got error=1 expected 0");
      end
   end

   task automatic power_up(input int hold);
      int n;
      rst = 1'b1;
      req_valid = 1'b0;
      repeat (hold) @(negedge clk);
      check("rst_pll_rst", 32'(pll_rst), 32'd1);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd1);
      check("rst_done", 32'(done), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_den", 32'(drp_den), 32'd0);
      check("rst_dwe", 32'(drp_dwe), 32'd0);
      check("rst_daddr", 32'(drp_daddr), 32'd0);
      check("rst_di", 32'(drp_di), 32'd0);
      check("rst_locked_out", 32'(locked_out), 32'd0);
      rst = 1'b0;
      n = 0;
      while (pll_rst === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("powerup_pll_rst_cycles", 32'(n), 32'd16);
      n = 0;
      while (locked_out !== 1'b1 && n < 600) begin
         n++;
         @(negedge clk);
      end
      check("powerup_locked_out", 32'(locked_out), 32'd1);
      check("powerup_req_ready", 32'(req_ready), 32'd1);
   endtask

   // Issue one request; pushes its expected DRP writes and completion
   task automatic issue(input int d, input logic [15:0] r1, input logic [15:0] r2,
                        input bit exp_err, input bit wr1_only, input bit push_done);
      int  k;
      int  dc;
      bit  legal;
      k = 0;
      while (req_ready !== 1'b1 && k < 5000) begin
         k++;
         @(negedge clk);
      end
      check("req_ready_before_request", 32'(req_ready), 32'd1);
      mem[8] = r1;
      mem[9] = r2;
      legal = (d >= 1) && (d <= 126);
      if (!legal) begin
         exp_done_q.push_back(1'b1);
      end else begin
         exp_wr_q.push_back({7'h08, ref_w1(d, r1)});
         if (!wr1_only) exp_wr_q.push_back({7'h09, ref_w2(d, r2)});
         if (push_done) exp_done_q.push_back(exp_err);
      end
      dc = den_count;
      req_divide = 8'(d);
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      if (legal) begin
         check("accept_pll_rst", 32'(pll_rst), 32'd1);
         check("accept_busy", 32'(busy), 32'd1);
         check("accept_req_ready", 32'(req_ready), 32'd0);
      end else begin
         check("illegal_done", 32'(done), 32'd1);
         check("illegal_error", 32'(error), 32'd1);
         check("illegal_pll_rst", 32'(pll_rst), 32'd0);
         check("illegal_busy", 32'(busy), 32'd0);
      end
      if (push_done) begin
         k = 0;
         while ((exp_done_q.size() != 0 || exp_wr_q.size() != 0) && k < 5000) begin
            k++;
            @(negedge clk);
         end
         check("sequence_complete", 32'(exp_done_q.size() + exp_wr_q.size()), 32'd0);
         @(negedge clk);
         if (!legal) check("no_den_on_illegal", 32'(den_count), 32'(dc));
      end
   endtask

   initial begin
      int k;
      int d;
      for (int i = 0; i < 128; i++) mem[i] = 16'h0000;

      power_up(3);

      issue(12, 16'h1041, 16'h0A80, 1'b0, 1'b0, 1'b1);
      check("locked_out_after_div12", 32'(locked_out), 32'd1);
      issue(7, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
      issue(1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
      check("locked_out_after_div1", 32'(locked_out), 32'd1);

      issue(0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1);
      issue(127, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1);
      issue(126, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1);

      // DRP timeout on the ClkReg1 write
      withhold_wr1 = 1'b1;
      issue(20, 16'h1234, 16'h5678, 1'b1, 1'b1, 1'b1);
      withhold_wr1 = 1'b0;
      issue(9, 16'hABCD, 16'h00FF, 1'b0, 1'b0, 1'b1);

      // Lock never returns
      never_lock = 1'b1;
      issue(50, 16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 1'b1);
      check("locked_out_after_lock_timeout", 32'(locked_out), 32'd0);
      never_lock = 1'b0;

      // Reset during the ClkReg2 write
      issue(33, 16'h1FFF, 16'h7777, 1'b0, 1'b0, 1'b0);
      k = 0;
      while (exp_wr_q.size() != 0 && k < 2000) begin
         k++;
         @(negedge clk);
      end
      check("reached_wr2", 32'(exp_wr_q.size()), 32'd0);
      power_up(1);
      issue(4, 16'h0000, 16'h1200, 1'b0, 1'b0, 1'b1);

      for (int i = 0; i < 8; i++) begin
         d = ($urandom_range(0, 9) == 0) ? $urandom_range(127, 255) : $urandom_range(0, 126);
         issue(d, 16'($urandom), 16'($urandom), (d < 1 || d > 126), 1'b0, 1'b1);
      end

      check("final_queues_empty", 32'(exp_done_q.size() + exp_wr_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #600000;
      miscompares++;
      $display("FAIL watchdog: got simulation still running expected completion");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
